// File: rtl/counter.sv
// Modulo-N up/down counter with terminal-count flag and registered wrap pulse.
// Define COUNTER_GRAY_EN to add a registered Gray-coded copy of the count on gray_o.
module counter #(
    parameter int unsigned BW      = 8,
    parameter int unsigned MOD_VAL = 0,
    parameter int unsigned STEP    = 1,
    parameter int unsigned DOWN    = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [BW-1:0] counter_val_o,
    output logic          tc_o,
    output logic          wrap_o
`ifdef COUNTER_GRAY_EN
    ,
    output logic [BW-1:0] gray_o
`endif
);

    // Modulus in 64 bits so that 2^BW is representable for BW = 32.
    localparam longint unsigned MOD_L = (MOD_VAL == 0) ? (64'd1 << BW) : 64'(MOD_VAL);

    if (BW < 1 || BW > 32) begin : g_bad_bw
        $error("counter: BW=%0d out of range 1..32", BW);
    end
    if (MOD_VAL == 1 || (MOD_VAL != 0 && 64'(MOD_VAL) > (64'd1 << BW))) begin : g_bad_mod
        $error("counter: MOD_VAL=%0d illegal for BW=%0d", MOD_VAL, BW);
    end
    if (STEP < 1 || 64'(STEP) >= MOD_L) begin : g_bad_step
        $error("counter: STEP=%0d illegal for modulus %0d", STEP, MOD_L);
    end
    if (DOWN > 1) begin : g_bad_down
        $error("counter: DOWN=%0d must be 0 or 1", DOWN);
    end

    // Arithmetic is done one bit wider than the count so nothing truncates before the compare.
    localparam logic [BW:0] MOD_W  = (BW+1)'(MOD_L);
    localparam logic [BW:0] STEP_W = (BW+1)'(STEP);

    logic [BW-1:0] count_q, count_d;
    logic          wrap_q;
    logic [BW:0]   cnt_ext;
    logic [BW:0]   next_ext;
    logic          tc;

    always_comb begin
        cnt_ext  = {1'b0, count_q};
        next_ext = '0;
        tc       = 1'b0;
        if (DOWN == 0) begin
            next_ext = cnt_ext + STEP_W;
            tc       = (next_ext >= MOD_W);
            if (tc) begin
                next_ext = next_ext - MOD_W;
            end
        end else begin
            tc = (cnt_ext < STEP_W);
            if (tc) begin
                next_ext = cnt_ext + MOD_W - STEP_W;
            end else begin
                next_ext = cnt_ext - STEP_W;
            end
        end
        count_d = BW'(next_ext);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= tc;
        end
    end

    assign counter_val_o = count_q;
    assign tc_o          = tc;
    assign wrap_o        = wrap_q;

`ifdef COUNTER_GRAY_EN
    logic [BW-1:0] gray_q, gray_d;

    // Encoded from the next count so gray_o lines up with counter_val_o in the same cycle.
    assign gray_d = count_d ^ (count_d >> 1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

    assign gray_o = gray_q;
`endif

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: three instances (BW=3 up, BW=4 mod-10 step-3 up, BW=3 down)
// sharing one clock and reset; table vectors plus model loop and async-reset sequence.
module tb_counter;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [2:0] aCnt, cCnt;
    logic [3:0] bCnt;
    logic       aTc, aWr, bTc, bWr, cTc, cWr;
`ifdef COUNTER_GRAY_EN
    logic [2:0] aGray, cGray;
    logic [3:0] bGray;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    counter #(.BW(3)) dutA (
        .clk_i(clk_i), .rst_i(rst_i), .counter_val_o(aCnt), .tc_o(aTc), .wrap_o(aWr)
`ifdef COUNTER_GRAY_EN
        , .gray_o(aGray)
`endif
    );

    counter #(.BW(4), .MOD_VAL(10), .STEP(3)) dutB (
        .clk_i(clk_i), .rst_i(rst_i), .counter_val_o(bCnt), .tc_o(bTc), .wrap_o(bWr)
`ifdef COUNTER_GRAY_EN
        , .gray_o(bGray)
`endif
    );

    counter #(.BW(3), .DOWN(1)) dutC (
        .clk_i(clk_i), .rst_i(rst_i), .counter_val_o(cCnt), .tc_o(cTc), .wrap_o(cWr)
`ifdef COUNTER_GRAY_EN
        , .gray_o(cGray)
`endif
    );

    typedef struct {
        logic rst;
        int   aC; logic aT; logic aW;
        int   bC; logic bT; logic bW;
        int   cC; logic cT; logic cW;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag,
                            input int eaC, input int eaT, input int eaW,
                            input int ebC, input int ebT, input int ebW,
                            input int ecC, input int ecT, input int ecW);
        checkOutput({tag, " A.count"}, int'(aCnt), eaC);
        checkOutput({tag, " A.tc"},    int'(aTc),  eaT);
        checkOutput({tag, " A.wrap"},  int'(aWr),  eaW);
        checkOutput({tag, " B.count"}, int'(bCnt), ebC);
        checkOutput({tag, " B.tc"},    int'(bTc),  ebT);
        checkOutput({tag, " B.wrap"},  int'(bWr),  ebW);
        checkOutput({tag, " C.count"}, int'(cCnt), ecC);
        checkOutput({tag, " C.tc"},    int'(cTc),  ecT);
        checkOutput({tag, " C.wrap"},  int'(cWr),  ecW);
`ifdef COUNTER_GRAY_EN
        begin
            int lut[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
            checkOutput({tag, " A.gray"}, int'(aGray), lut[eaC]);
            checkOutput({tag, " C.gray"}, int'(cGray), lut[ecC]);
            checkOutput({tag, " B.gray"}, int'(bGray), ebC ^ (ebC >> 1));
        end
`endif
    endtask

    task automatic applyStimulus(input logic r);
        rst_i = r;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int k;
        int ea, eb, ec, ebPrev;
        bit found;

        // Three cycles in reset, then k = 1..12 edges after release.
        vecs[0]  = '{0, 0,0,0, 0,0,0, 0,1,0};
        vecs[1]  = '{0, 0,0,0, 0,0,0, 0,1,0};
        vecs[2]  = '{0, 0,0,0, 0,0,0, 0,1,0};
        vecs[3]  = '{1, 1,0,0, 3,0,0, 7,0,1};
        vecs[4]  = '{1, 2,0,0, 6,0,0, 6,0,0};
        vecs[5]  = '{1, 3,0,0, 9,1,0, 5,0,0};
        vecs[6]  = '{1, 4,0,0, 2,0,1, 4,0,0};
        vecs[7]  = '{1, 5,0,0, 5,0,0, 3,0,0};
        vecs[8]  = '{1, 6,0,0, 8,1,0, 2,0,0};
        vecs[9]  = '{1, 7,1,0, 1,0,1, 1,0,0};
        vecs[10] = '{1, 0,0,1, 4,0,0, 0,1,0};
        vecs[11] = '{1, 1,0,0, 7,1,0, 7,0,1};
        vecs[12] = '{1, 2,0,0, 0,0,1, 6,0,0};
        vecs[13] = '{1, 3,0,0, 3,0,0, 5,0,0};
        vecs[14] = '{1, 4,0,0, 6,0,0, 4,0,0};

        #1;
        checkAll("t0 reset", 0,0,0, 0,0,0, 0,1,0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rst);
            checkAll($sformatf("vec%0d", i),
                     vecs[i].aC, int'(vecs[i].aT), int'(vecs[i].aW),
                     vecs[i].bC, int'(vecs[i].bT), int'(vecs[i].bW),
                     vecs[i].cC, int'(vecs[i].cT), int'(vecs[i].cW));
        end

        // Longer run against a closed-form model of each sequence.
        for (k = 13; k <= 40; k++) begin
            applyStimulus(1'b1);
            ea     = k % 8;
            ec     = (8 - (k % 8)) % 8;
            eb     = (3 * k) % 10;
            ebPrev = (3 * (k - 1)) % 10;
            checkAll($sformatf("run k=%0d", k),
                     ea, int'(ea == 7), int'(ea == 0),
                     eb, int'(eb >= 7), int'(ebPrev >= 7),
                     ec, int'(ec == 0), int'(ec == 7));
        end

        // Advance A to 5, then drop reset between edges.
        found = 0;
        for (int n = 0; n < 16 && !found; n++) begin
            applyStimulus(1'b1);
            if (aCnt == 3'd5) found = 1;
        end
        checkOutput("reach A=5", int'(found), 1);

        #2;
        rst_i = 1'b0;
        #1;
        checkAll("async reset", 0,0,0, 0,0,0, 0,1,0);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0);
            checkAll($sformatf("held reset %0d", n), 0,0,0, 0,0,0, 0,1,0);
        end
        applyStimulus(1'b1);
        checkAll("post release 1", 1,0,0, 3,0,0, 7,0,1);
        applyStimulus(1'b1);
        checkAll("post release 2", 2,0,0, 6,0,0, 6,0,0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
